bsg_reset_release_sequencer: RTL and testbench
==============================================

// Module: bsg_reset_release_sequencer
// PURPOSE
// - Staged reset release for N clock-synchronous domains (BP tile, crossbar, IO, mems, ...).
// - After start_i (e.g. bsg_tag replay done), releases reset_o[0..N-1] in index order.
// - Each domain k is released a runtime-programmable delay_i[k] gap after domain k-1.
// - abort_i re-asserts every domain at once.
// - Generalises a single "reset | ~done" gate to N domains with ordering, gaps and re-arm.
// PARAMETERS
// - num_domains_p  3   number of reset domains (>=1)
// - delay_width_p  8   width of each per-domain gap counter
// - hold_cycles_p  4   min cycles all resets stay asserted after reset_n_i/abort (>=1)
// PORTS
// - clk_i        in   1                            single clock
// - reset_n_i    in   1                            asynchronous, active-low reset
// - start_i      in   1                            begin release; sampled in IDLE only
// - abort_i      in   1                            re-assert all domains; any state
// - delay_i      in   num_domains_p*delay_width_p  gap for domain k in [k*dw +: dw]
// - reset_o      out  num_domains_p                active-high per-domain resets
// - busy_o       out  1                            high in HOLD or COUNT
// - done_o       out  1                            all domains released
// - domain_o     out  clog2(num_domains_p)         index being counted
// BEHAVIOUR
// - Async reset (reset_n_i=0), applied immediately, not clocked:
//   - reset_o all 1; done_o=0; busy_o=1; domain_o=0; counter=hold_cycles_p-1; state HOLD.
// - All outputs are registered; reset_o bits deassert only on a clk_i edge.
// - State HOLD:
//   - Counter decrements each cycle.
//   - At counter==0 go to IDLE next edge; HOLD lasts exactly hold_cycles_p cycles.
//   - start_i is ignored in HOLD.
// - State IDLE:
//   - reset_o all 1; busy_o=0.
//   - start_i=1 at edge T0 -> COUNT, domain=0, counter=delay_i[0] sampled at T0.
// - State COUNT:
//   - Counter nonzero: decrement.
//   - Counter==0: clear reset_o[domain] at next edge.
//     - If domain==N-1: go to DONE at that same edge.
//     - Else: domain+1, load counter=delay_i[domain+1] at that same edge.
//   - Timing: domain 0 falls at edge T0+d0+1; domain k falls d_k+1 edges after domain k-1.
//   - delay_i sampled only at load; later changes do not affect a running gap.
//   - delay 0 gives adjacent-cycle release; max gap is 2^delay_width_p edges.
//   - start_i during COUNT/DONE: ignored (no restart, no extension).
// - State DONE:
//   - reset_o all 0; done_o=1; busy_o=0.
//   - Stays until abort_i or reset_n_i.
// - abort_i=1 at any edge, any state (including HOLD):
//   - reset_o all 1, done_o=0, domain=0, counter=hold_cycles_p-1, state HOLD.
//   - abort takes priority over start_i and over a release due on the same edge.
//   - abort held high keeps state in HOLD, counter reloaded every edge.
// - reset_n_i low mid-sequence: every domain re-asserted asynchronously, same as power-up.
// - Invariant: reset_o[k]==0 implies reset_o[j]==0 for all j<k (no out-of-order release).
// - num_domains_p==1: domain_o is 1 bit wide, tied to 0.
// TESTING
// - Power-up (N=3, hold=4, delays {2,0,5}), start_i pulse 1 cycle after HOLD->IDLE:
//   - reset_o[0] falls at T0+3, [1] at T0+4, [2] at T0+10.
//   - done_o rises at T0+10.
// - start_i asserted during HOLD -> ignored.
//   - start_i held through HOLD into IDLE: sequence starts at first IDLE edge.
// - abort_i mid-COUNT (after domain 0 released):
//   - Next edge: reset_o=3'b111, done_o=0.
//   - busy_o stays high 4 cycles, then IDLE; a new start_i replays full timing.
// - abort_i and a due release on the same edge -> no bit clears, all reset_o=1.
// - reset_n_i low for 1 ps mid-COUNT -> reset_o=3'b111 before next clk edge.
//   - Then HOLD of 4 cycles.
// - delays all 8'hFF: gaps of 256 edges each.
//   - delay_i changed mid-gap: current gap unchanged, next domain uses new value.
//   - Assertion checks the release-order invariant every cycle.

Source files
------------

// File: rtl/bsg_reset_release_sequencer.sv
// Staged reset release for several clock-synchronous domains: after start_i the
// per-domain resets fall in index order, each a programmable gap after the previous.
module bsg_reset_release_sequencer #(
   parameter int num_domains_p = 3,
   parameter int delay_width_p = 8,
   parameter int hold_cycles_p = 4,
   localparam int dom_w_lp = (num_domains_p > 1) ? $clog2(num_domains_p) : 1
) (
   input  logic                                   clk_i,
   input  logic                                   reset_n_i,
   input  logic                                   start_i,
   input  logic                                   abort_i,
   input  logic [num_domains_p*delay_width_p-1:0] delay_i,
   output logic [num_domains_p-1:0]               reset_o,
   output logic                                   busy_o,
   output logic                                   done_o,
   output logic [dom_w_lp-1:0]                    domain_o
);

   localparam int hold_w_lp = (hold_cycles_p > 1) ? $clog2(hold_cycles_p) : 1;
   localparam int cnt_w_lp  = (delay_width_p > hold_w_lp) ? delay_width_p : hold_w_lp;
   localparam logic [cnt_w_lp-1:0] hold_load_lp = cnt_w_lp'(hold_cycles_p - 1);
   localparam logic [dom_w_lp-1:0] last_dom_lp  = dom_w_lp'(num_domains_p - 1);

   typedef enum logic [1:0] {
      st_hold,
      st_idle,
      st_count,
      st_done
   } state_e;

   state_e                    state_r, state_n;
   logic [cnt_w_lp-1:0]       cnt_r, cnt_n;
   logic [dom_w_lp-1:0]       domain_r, domain_n, dom_inc;
   logic [num_domains_p-1:0]  resets_r, resets_n;
   logic                      busy_r, busy_n;
   logic                      done_r, done_n;
   logic [delay_width_p-1:0]  delay_a [num_domains_p];

   always_comb begin
      for (int k = 0; k < num_domains_p; k++) begin
         delay_a[k] = delay_i[k*delay_width_p +: delay_width_p];
      end
   end

   always_comb begin
      state_n  = state_r;
      cnt_n    = cnt_r;
      domain_n = domain_r;
      resets_n = resets_r;
      // Saturate so the delay lookup never indexes past the last domain.
      dom_inc  = (domain_r == last_dom_lp) ? domain_r : domain_r + 1'b1;

      if (abort_i) begin
         state_n  = st_hold;
         cnt_n    = hold_load_lp;
         domain_n = '0;
         resets_n = '1;
      end else begin
         case (state_r)
            st_hold: begin
               if (cnt_r == '0) state_n = st_idle;
               else             cnt_n   = cnt_r - 1'b1;
            end
            st_idle: begin
               resets_n = '1;
               if (start_i) begin
                  state_n  = st_count;
                  domain_n = '0;
                  cnt_n    = cnt_w_lp'(delay_a[0]);
               end
            end
            st_count: begin
               if (cnt_r != '0) begin
                  cnt_n = cnt_r - 1'b1;
               end else begin
                  for (int k = 0; k < num_domains_p; k++) begin
                     if (dom_w_lp'(k) == domain_r) resets_n[k] = 1'b0;
                  end
                  if (domain_r == last_dom_lp) begin
                     state_n = st_done;
                  end else begin
                     domain_n = dom_inc;
                     cnt_n    = cnt_w_lp'(delay_a[dom_inc]);
                  end
               end
            end
            st_done: begin
               resets_n = '0;
            end
            default: begin
               state_n  = st_hold;
               cnt_n    = hold_load_lp;
               domain_n = '0;
               resets_n = '1;
            end
         endcase
      end

      busy_n = (state_n == st_hold) || (state_n == st_count);
      done_n = (state_n == st_done);
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r  <= st_hold;
         cnt_r    <= hold_load_lp;
         domain_r <= '0;
         resets_r <= '1;
         busy_r   <= 1'b1;
         done_r   <= 1'b0;
      end else begin
         state_r  <= state_n;
         cnt_r    <= cnt_n;
         domain_r <= domain_n;
         resets_r <= resets_n;
         busy_r   <= busy_n;
         done_r   <= done_n;
      end
   end

   assign reset_o  = resets_r;
   assign busy_o   = busy_r;
   assign done_o   = done_r;
   assign domain_o = domain_r;

endmodule

// File: tb/tb_bsg_reset_release_sequencer.sv
// Scoreboard bench for bsg_reset_release_sequencer: release times are queued at
// start and popped as each reset_o bit falls.
module tb_bsg_reset_release_sequencer;

   localparam int N  = 3;
   localparam int DW = 8;

   logic              clk = 1'b0;
   logic              reset_n = 1'b1;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [N*DW-1:0]   delay = '0;
   logic [N-1:0]      reset_o;
   logic              busy_o;
   logic              done_o;
   logic [1:0]        domain_o;

   int     checks = 0;
   int     errors = 0;
   longint cyc = 0;

   typedef struct {
      int     dom;
      longint at;
   } rel_t;
   rel_t exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bsg_reset_release_sequencer #(
      .num_domains_p(N),
      .delay_width_p(DW),
      .hold_cycles_p(4)
   ) dut (
      .clk_i    (clk),
      .reset_n_i(reset_n),
      .start_i  (start),
      .abort_i  (abort),
      .delay_i  (delay),
      .reset_o  (reset_o),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .domain_o (domain_o)
   );

   // Release-order invariant: a cleared bit implies every lower bit is cleared.
   always @(negedge clk) begin
      for (int k = 1; k < N; k++) begin
         assert (!(reset_o[k] === 1'b0 && reset_o[k-1] !== 1'b0)) else begin
            errors++;
            $display("FAIL order_invariant reset_o=%b at cycle %0d", reset_o, cyc);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input longint t0, input logic [N*DW-1:0] dv);
      rel_t   e;
      longint t = t0;
      for (int k = 0; k < N; k++) begin
         t = t + longint'(dv[k*DW +: DW]) + 1;
         e.dom = k;
         e.at  = t;
         exp_q.push_back(e);
      end
   endtask

   task automatic launch(input logic [N*DW-1:0] dv);
      delay = dv;
      start = 1'b1;
      tick();
      start = 1'b0;
      push_exp(cyc, dv);
      checks++;
      if (domain_o !== 2'd0 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL launch_state domain=%0d busy=%b expected domain=0 busy=1", domain_o, busy_o);
      end
   endtask

   task automatic drain(input int budget);
      logic [N-1:0] prev;
      logic [N-1:0] fell;
      rel_t         e;
      int           n = 0;
      prev = reset_o;
      while (exp_q.size() > 0 && n < budget) begin
         tick();
         n++;
         fell = prev & ~reset_o;
         for (int k = 0; k < N; k++) begin
            if (fell[k]) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL release_unexpected domain %0d at cycle %0d expected none", k, cyc);
               end else begin
                  e = exp_q.pop_front();
                  if (e.dom != k || e.at != cyc) begin
                     errors++;
                     $display("FAIL release_time domain %0d at cycle %0d expected domain %0d at cycle %0d",
                              k, cyc, e.dom, e.at);
                  end
               end
               checks++;
               if (domain_o !== 2'((k < N-1) ? k + 1 : N - 1)) begin
                  errors++;
                  $display("FAIL domain_index got %0d after release of %0d expected %0d",
                           domain_o, k, (k < N-1) ? k + 1 : N - 1);
               end
            end
         end
         prev = reset_o;
      end
      checks++;
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL release_timeout %0d releases outstanding, reset_o=%b expected all released",
                  exp_q.size(), reset_o);
         exp_q.delete();
      end else if (done_o !== 1'b1 || reset_o !== '0) begin
         errors++;
         $display("FAIL done_at_last got done=%b reset_o=%b expected done=1 reset_o=000", done_o, reset_o);
      end
   endtask

   task automatic rearm;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      repeat (4) tick();
   endtask

   task automatic wait_bit0;
      int n = 0;
      while (reset_o[0] !== 1'b0 && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (reset_o[0] !== 1'b0) begin
         errors++;
         $display("FAIL wait_bit0 reset_o=%b expected bit0 cleared", reset_o);
      end
      exp_q.delete();
   endtask

   task automatic test_reset;
      #1 reset_n = 1'b0;
      #1;
      checks++;
      if (reset_o !== 3'b111 || busy_o !== 1'b1 || done_o !== 1'b0 || domain_o !== 2'd0) begin
         errors++;
         $display("FAIL reset_values reset_o=%b busy=%b done=%b domain=%0d expected 111 1 0 0",
                  reset_o, busy_o, done_o, domain_o);
      end
      tick();
      tick();
      reset_n = 1'b1;
      repeat (3) tick();
      checks++;
      if (busy_o !== 1'b1 || reset_o !== 3'b111) begin
         errors++;
         $display("FAIL hold_busy busy=%b reset_o=%b expected 1 111", busy_o, reset_o);
      end
      tick();
      checks++;
      if (busy_o !== 1'b0 || reset_o !== 3'b111 || done_o !== 1'b0) begin
         errors++;
         $display("FAIL hold_exit busy=%b reset_o=%b done=%b expected 0 111 0", busy_o, reset_o, done_o);
      end
   endtask

   task automatic test_power_up;
      tick();
      launch({8'd5, 8'd0, 8'd2});
      drain(50);
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL done_busy busy=%b expected 0", busy_o);
      end
   endtask

   task automatic test_start_in_done;
      start = 1'b1;
      repeat (3) tick();
      start = 1'b0;
      tick();
      checks++;
      if (reset_o !== 3'b000 || done_o !== 1'b1 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL start_in_done reset_o=%b done=%b busy=%b expected 000 1 0", reset_o, done_o, busy_o);
      end
   endtask

   task automatic test_abort_mid_count;
      rearm();
      launch({8'd5, 8'd0, 8'd2});
      wait_bit0();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if (reset_o !== 3'b111 || done_o !== 1'b0 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL abort_count reset_o=%b done=%b busy=%b expected 111 0 1", reset_o, done_o, busy_o);
      end
      repeat (3) tick();
      checks++;
      if (busy_o !== 1'b1) begin
         errors++;
         $display("FAIL abort_hold busy=%b expected 1", busy_o);
      end
      tick();
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle busy=%b expected 0", busy_o);
      end
      launch({8'd5, 8'd0, 8'd2});
      drain(50);
   endtask

   task automatic test_abort_same_edge;
      rearm();
      delay = '0;
      start = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if (reset_o !== 3'b111 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL abort_vs_release reset_o=%b busy=%b expected 111 1", reset_o, busy_o);
      end
      repeat (4) tick();
      checks++;
      if (busy_o !== 1'b0 || reset_o !== 3'b111) begin
         errors++;
         $display("FAIL abort_vs_release_idle busy=%b reset_o=%b expected 0 111", busy_o, reset_o);
      end
   endtask

   task automatic test_start_during_hold;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b1;
      delay = {8'd1, 8'd1, 8'd1};
      repeat (4) tick();
      checks++;
      if (busy_o !== 1'b0 || reset_o !== 3'b111) begin
         errors++;
         $display("FAIL start_in_hold busy=%b reset_o=%b expected 0 111", busy_o, reset_o);
      end
      tick();
      start = 1'b0;
      push_exp(cyc, {8'd1, 8'd1, 8'd1});
      drain(50);
   endtask

   task automatic test_async_reset;
      rearm();
      launch({8'd5, 8'd0, 8'd2});
      wait_bit0();
      #1 reset_n = 1'b0;
      #1;
      checks++;
      if (reset_o !== 3'b111 || busy_o !== 1'b1 || done_o !== 1'b0 || domain_o !== 2'd0) begin
         errors++;
         $display("FAIL async_reset reset_o=%b busy=%b done=%b domain=%0d expected 111 1 0 0",
                  reset_o, busy_o, done_o, domain_o);
      end
      #1 reset_n = 1'b1;
      repeat (3) tick();
      checks++;
      if (busy_o !== 1'b1) begin
         errors++;
         $display("FAIL async_hold busy=%b expected 1", busy_o);
      end
      tick();
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL async_idle busy=%b expected 0", busy_o);
      end
   endtask

   task automatic test_max_delay;
      launch({8'hFF, 8'hFF, 8'hFF});
      drain(900);
      rearm();
      launch({8'hFF, 8'hFF, 8'hFF});
      exp_q.delete();
      push_exp(cyc - 1 + 1, {8'd3, 8'd3, 8'hFF});
      repeat (100) tick();
      delay = {8'd3, 8'd3, 8'h10};
      drain(600);
   endtask

   initial begin
      test_reset();
      test_power_up();
      test_start_in_done();
      test_abort_mid_count();
      test_abort_same_edge();
      test_start_during_hold();
      test_async_reset();
      test_max_delay();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
